// File: rtl/result_fifo.sv
// Result FIFO between the AND stage and its consumer: first-word fall-through, sticky overflow.
// Define RESULT_FIFO_PARITY_EN to store an even-parity bit per entry and expose out_parity.
module result_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow
`ifdef RESULT_FIFO_PARITY_EN
   ,
   output logic                       out_parity
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             push;
   logic             pop;

   // Ready depends only on registered count, so a full FIFO refuses even during a pop.
   assign in_ready  = (count != FULL_COUNT);
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (in_valid && !in_ready) begin
            overflow <= 1'b1;
         end
      end
   end

`ifdef RESULT_FIFO_PARITY_EN
   logic par_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (push) begin
         par_mem[wr_ptr] <= ^in_data;
      end
   end

   // Parity storage is not reset, so mask it while empty.
   assign out_parity = out_valid ? par_mem[rd_ptr] : 1'b0;
`endif

endmodule

// File: doc/result_fifo.md
RESULT_FIFO -- requirements
Module: result_fifo

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: bit width of each result word (matches the 8-bit Y of the AND stage).
- REQ-002 SHALL have parameter DEPTH, default 4: number of entries, power of two, minimum 2.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port in_data, input, WIDTH bits: result word from the upstream AND stage.
- REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
- REQ-007 SHALL have port in_ready, output, 1 bit: FIFO accepts a word this cycle.
- REQ-008 SHALL have port out_data, output, WIDTH bits: oldest stored word.
- REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a stored word.
- REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
- REQ-011 SHALL have port count, output, log2(DEPTH)+1 bits: number of stored entries.
- REQ-012 SHALL have port overflow, output, 1 bit: sticky flag set when a push is refused.

Function
- REQ-013 SHALL push when in_valid and in_ready are both 1 at a rising edge, and pop when out_valid and out_ready are both 1 at a rising edge.
- REQ-014 SHALL drive in_ready = (count != DEPTH), combinationally from the registered count only, with no dependence on out_ready.
- REQ-015 SHALL drive out_valid = (count != 0); out_data SHALL be the entry at the read pointer (first-word fall-through); out_data is don't-care while out_valid = 0.
- REQ-016 SHALL make a word pushed at edge N visible on out_data/out_valid after edge N (1-cycle latency); empty-FIFO bypass is not allowed.
- REQ-017 SHALL, on simultaneous push and pop, leave count unchanged and advance both pointers.
- REQ-018 SHALL refuse a push when full, even if a pop occurs in the same cycle; the popped slot becomes available the next cycle.
- REQ-019 SHALL ignore out_ready when empty, with no pointer or count change.
- REQ-020 SHALL wrap the read and write pointers modulo DEPTH; count SHALL never exceed DEPTH or drop below 0.
- REQ-021 SHALL set overflow to 1 at any edge where in_valid=1 and in_ready=0; overflow SHALL clear only on reset.
- REQ-022 SHALL preserve word order strictly (FIFO) and never alter data bits.

Reset
- REQ-023 SHALL, when reset=1 at a rising edge, clear count, both pointers and overflow to 0, and discard any push or pop in that cycle.
- REQ-024 SHALL output in_ready=1, out_valid=0 and count=0 after reset.
- REQ-025 SHALL NOT require memory contents to be reset.
- REQ-026 SHALL discard stored entries when reset is asserted mid-operation.

Configuration
- REQ-027 SHALL, when RESULT_FIFO_PARITY_EN is defined, store one even-parity bit per entry, computed from in_data at push.
- REQ-028 SHALL, when RESULT_FIFO_PARITY_EN is defined, add output port out_parity (1 bit) aligned with out_data; out_parity SHALL be 0 after reset while empty.
- REQ-029 SHALL, when RESULT_FIFO_PARITY_EN is undefined, have no out_parity port and no parity storage; all other behaviour SHALL be identical.

Verification
- REQ-030 SHALL verify reset: hold reset 2 cycles, then release -> in_ready=1, out_valid=0, count=0, overflow=0.
- REQ-031 SHALL verify latency: push 0xA5 with out_ready=0 -> next cycle out_valid=1, out_data=0xA5, count=1.
- REQ-032 SHALL verify fill and overflow: push 0x01, 0x02, 0x03, 0x04, then present 0x05 -> in_ready=0, 0x05 dropped, overflow=1, count=4; drain with out_ready=1 -> outputs 0x01..0x04 in order, overflow still 1.
- REQ-033 SHALL verify simultaneous push/pop: with count=2, push 0x10 and pop together for 6 cycles -> count stays 2 and the order is preserved through pointer wrap.
- REQ-034 SHALL verify mid-operation reset: with count=3, assert reset for 1 cycle while in_valid=1 -> count=0, out_valid=0, overflow=0, and the input word is not stored.
- REQ-035 SHALL verify parity (with RESULT_FIFO_PARITY_EN defined): push 0x07 then 0x03 -> out_parity=1, then 0.
